qlearn_episode_ctrl: RTL
========================

// Module: qlearn_episode_ctrl
// PURPOSE
//  Episode/step sequencer for the maze Q-learning datapath. Holds current_state and
//  drives the state selector and reward generator. Picks each action epsilon-greedily
//  (agent's greedy action vs. LFSR random). Issues one Q-update per step and handshakes
//  with the agent. Counts steps and episodes and stops after NUM_EPISODES.
// PARAMETERS
//  START_STATE   6'd0      state loaded at the start of every episode
//  GOAL_STATE    6'd35     terminal state; reaching it ends the episode
//  MAX_STEPS     64        step limit per episode (1..255)
//  NUM_EPISODES  100       episodes per run (1..65535)
//  LFSR_SEED     16'hACE1  LFSR reset value; must be nonzero
// PORTS
//  clk            in   1   clock
//  rst            in   1   synchronous reset, active-high
//  en             in   1   advance enable; low = every register holds, outputs hold
//  start          in   1   level; IDLE->INIT when high
//  epsilon        in   8   explore threshold; explore when lfsr[7:0] < epsilon
//  greedy_action  in   4   one-hot argmax action from agent (0001 U,0010 D,0100 L,1000 R)
//  next_state     in   6   from state selector (comb. of current_state, action)
//  reward         in  16   signed reward from reward generator for next_state
//  q_done         in   1   agent has finished the requested Q-table update
//  current_state  out  6   maze state fed to the state selector
//  action         out  4   one-hot chosen action
//  q_update       out  1   one-cycle request to the agent to update Q(s,a)
//  step_reward    out 16   reward latched for the current update
//  step_cnt       out  8   steps taken in the current episode
//  episode_cnt    out 16   completed episodes
//  busy           out  1   high in every state except IDLE and DONE
//  done           out  1   high in DONE
// BEHAVIOUR
//  - Reset (rst high at a clk edge, overrides en): state=IDLE, current_state=START_STATE,
//    action=0, q_update=0, step_reward=0, step_cnt=0, episode_cnt=0, lfsr=LFSR_SEED,
//    busy=0, done=0. Reset mid-episode abandons the episode and issues no further q_update.
//  - All transitions below happen only on edges where en=1.
//  - FSM states: IDLE, INIT, SELECT, SETTLE, UPDATE, ADVANCE, EP_END, DONE.
//  - IDLE: if start, go to INIT and clear episode_cnt.
//  - INIT: current_state<=START_STATE, step_cnt<=0, go to SELECT.
//  - SELECT (1 cycle): explore = (lfsr[7:0] < epsilon).
//    - If explore: action <= one-hot of lfsr[9:8].
//    - Else: action <= greedy_action. If greedy_action is not exactly one-hot, use 4'b0001.
//    - LFSR advances once, here only: 16-bit Galois, taps x^16+x^14+x^13+x^11+1.
//    - Go to SETTLE.
//  - SETTLE (1 cycle): lets selector and reward settle. Latch ns_q<=next_state and
//    step_reward<=reward. Set q_update<=1 and go to UPDATE.
//  - UPDATE: q_update is high only on the first UPDATE cycle.
//    - q_done is accepted on any UPDATE cycle, including the first; then go to ADVANCE.
//    - current_state, action and step_reward stay stable throughout UPDATE.
//  - ADVANCE: current_state<=ns_q, step_cnt<=step_cnt+1.
//    - If ns_q==GOAL_STATE or step_cnt+1==MAX_STEPS, go to EP_END.
//    - Otherwise go to SELECT. The goal test takes priority only in naming; both end the episode.
//  - EP_END: episode_cnt<=episode_cnt+1. If episode_cnt+1==NUM_EPISODES go to DONE,
//    else go to INIT.
//  - DONE: done=1, counters hold. Go to IDLE when start=0. A new start clears episode_cnt.
//  - Per-step latency with q_done high in the first UPDATE cycle:
//    SELECT, SETTLE, UPDATE, ADVANCE = 4 cycles.
//  - Counter widths: no wrap. The parameter ranges keep the counters in range.
// TESTING
//  1 rst=1, en=1 -> all outputs match reset values; current_state=START_STATE; busy=0.
//  2 epsilon=0, greedy=0100, model next_state=cur+1, GOAL=3, q_done tied 1, start
//    -> 3 q_update pulses 4 cycles apart, episode_cnt=1, current_state back to 0.
//  3 MAX_STEPS=4, next_state never GOAL -> EP_END after exactly 4 pulses, step_cnt=4 then 0.
//  4 q_done delayed 5 cycles -> q_update high 1 cycle only; action, state, step_reward
//    stable; ADVANCE one cycle after q_done.
//  5 en=0 for 3 cycles mid-UPDATE, then rst mid-episode -> nothing changes during en=0;
//    after rst: IDLE, counters 0, no q_update.
//  6 NUM_EPISODES=2, epsilon=255, seed ACE1 -> every action one-hot, >=3 distinct over
//    the run, done=1 after 2nd EP_END, IDLE once start=0.

Source files
------------

// File: rtl/qlearn_episode_ctrl.sv
// Episode/step sequencer for the maze Q-learning datapath: epsilon-greedy action
// choice, one Q-update handshake per step, step/episode counting.
//
// state     | meaning
// S_IDLE    | waiting for start
// S_INIT    | load start state, clear step count
// S_SELECT  | choose action (explore vs greedy), advance LFSR
// S_SETTLE  | latch next_state and reward, raise q_update
// S_UPDATE  | wait for q_done from the agent
// S_ADVANCE | move to latched next state, count the step
// S_EP_END  | count the episode, decide DONE vs next episode
// S_DONE    | run finished, hold until start drops
module qlearn_episode_ctrl #(
  parameter logic [5:0]  START_STATE  = 6'd0,
  parameter logic [5:0]  GOAL_STATE   = 6'd35,
  parameter int unsigned MAX_STEPS    = 64,
  parameter int unsigned NUM_EPISODES = 100,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        start,
  input  logic [7:0]  epsilon,
  input  logic [3:0]  greedy_action,
  input  logic [5:0]  next_state,
  input  logic [15:0] reward,
  input  logic        q_done,
  output logic [5:0]  current_state,
  output logic [3:0]  action,
  output logic        q_update,
  output logic [15:0] step_reward,
  output logic [7:0]  step_cnt,
  output logic [15:0] episode_cnt,
  output logic        busy,
  output logic        done
);

  localparam logic [7:0]  MAX_STEPS_C = 8'(MAX_STEPS);
  localparam logic [15:0] NUM_EP_C    = 16'(NUM_EPISODES);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_SELECT, S_SETTLE, S_UPDATE, S_ADVANCE, S_EP_END, S_DONE
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] lfsr, lfsr_nxt;
  logic [5:0]  ns_q;
  logic [3:0]  action_sel;
  logic [7:0]  step_inc;
  logic [15:0] ep_inc;
  logic        explore, greedy_ok;

  // Galois form of x^16+x^14+x^13+x^11+1, shifting right
  assign lfsr_nxt  = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
  assign explore   = lfsr[7:0] < epsilon;
  assign greedy_ok = (greedy_action != 4'b0000) &&
                     ((greedy_action & (greedy_action - 4'd1)) == 4'b0000);
  assign step_inc  = step_cnt + 8'd1;
  assign ep_inc    = episode_cnt + 16'd1;
  assign busy      = (state != S_IDLE) && (state != S_DONE);
  assign done      = (state == S_DONE);

  always_comb begin
    action_sel = 4'b0001;
    if (explore)        action_sel = 4'b0001 << lfsr[9:8];
    else if (greedy_ok) action_sel = greedy_action;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (start) state_nxt = S_INIT;
      S_INIT:    state_nxt = S_SELECT;
      S_SELECT:  state_nxt = S_SETTLE;
      S_SETTLE:  state_nxt = S_UPDATE;
      S_UPDATE:  if (q_done) state_nxt = S_ADVANCE;
      S_ADVANCE: state_nxt = (ns_q == GOAL_STATE || step_inc == MAX_STEPS_C) ? S_EP_END : S_SELECT;
      S_EP_END:  state_nxt = (ep_inc == NUM_EP_C) ? S_DONE : S_INIT;
      S_DONE:    if (!start) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else if (en) state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      current_state <= START_STATE;
      action        <= 4'b0000;
      q_update      <= 1'b0;
      step_reward   <= 16'd0;
      step_cnt      <= 8'd0;
      episode_cnt   <= 16'd0;
      lfsr          <= LFSR_SEED;
      ns_q          <= 6'd0;
    end else if (en) begin
      // Pulse covers only the first UPDATE cycle
      q_update <= (state == S_SETTLE);
      case (state)
        S_IDLE: if (start) episode_cnt <= 16'd0;
        S_INIT: begin
          current_state <= START_STATE;
          step_cnt      <= 8'd0;
        end
        S_SELECT: begin
          action <= action_sel;
          lfsr   <= lfsr_nxt;
        end
        S_SETTLE: begin
          ns_q        <= next_state;
          step_reward <= reward;
        end
        S_ADVANCE: begin
          current_state <= ns_q;
          step_cnt      <= step_inc;
        end
        S_EP_END: episode_cnt <= ep_inc;
        default: ;
      endcase
    end
  end

endmodule
